// File: rtl/shapkg.sv
// shapkg: SHA-256 sizes, round constants, schedule state type and word functions.
package shapkg;
  localparam int SHA_WORD_W = 32;
  localparam int SHA_BLK_WORDS = 16;
  localparam int SHA_ROUNDS = 64;
  typedef enum logic {ST_IDLE, ST_RUN} sched_state_t;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] sha_rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sha_big_sigma0(input logic [31:0] x);
    return sha_rotr(x, 2) ^ sha_rotr(x, 13) ^ sha_rotr(x, 22);
  endfunction
  function automatic logic [31:0] sha_big_sigma1(input logic [31:0] x);
    return sha_rotr(x, 6) ^ sha_rotr(x, 11) ^ sha_rotr(x, 25);
  endfunction
  function automatic logic [31:0] sha_sigma0(input logic [31:0] x);
    return sha_rotr(x, 7) ^ sha_rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sha_sigma1(input logic [31:0] x);
    return sha_rotr(x, 17) ^ sha_rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/ethz_csa.sv
// ethz_csa: 3:2 carry-save adder; carry is pre-shifted so sum + carry equals a + b + c.
module ethz_csa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);
  assign sum = a ^ b ^ c;
  assign carry = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: streams W_t/K_t for 64 rounds from one 512-bit block via a rolling 16-word window.
module sha256_msg_schedule
  import shapkg::*;
#(
  parameter int NUM_ROUNDS = SHA_ROUNDS,
  parameter int BLK_W = SHA_BLK_WORDS * SHA_WORD_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          blk_valid_i,
  output logic                          blk_ready_o,
  input  logic [BLK_W-1:0]              blk_i,
  output logic                          w_valid_o,
  input  logic                          round_ready_i,
  output logic [31:0]                   w_o,
  output logic [31:0]                   k_o,
  output logic [$clog2(NUM_ROUNDS)-1:0] round_o,
  output logic                          last_o,
  output logic                          done_o
);
  localparam int RW = $clog2(NUM_ROUNDS);
  if (NUM_ROUNDS != 64 || BLK_W != 512) begin : g_bad_cfg
    $error("sha256_msg_schedule supports only NUM_ROUNDS=64 and BLK_W=512");
  end
  sched_state_t state;
  logic [SHA_WORD_W-1:0] win [SHA_BLK_WORDS];
  logic [RW-1:0] t;
  logic [SHA_WORD_W-1:0] s1, c1, s2, c2, new_w;
  logic last;
  // new_w = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t]: two CSA levels, one carry-propagate add
  ethz_csa #(.WIDTH(SHA_WORD_W)) u_csa0 (
    .a(sha_sigma1(win[14])), .b(win[9]), .c(sha_sigma0(win[1])), .sum(s1), .carry(c1)
  );
  ethz_csa #(.WIDTH(SHA_WORD_W)) u_csa1 (
    .a(s1), .b(c1), .c(win[0]), .sum(s2), .carry(c2)
  );
  assign new_w = s2 + c2;
  assign last = w_valid_o && t == RW'(NUM_ROUNDS - 1);
  assign last_o = last;
  assign w_o = win[0];
  assign k_o = K[t];
  assign round_o = t;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      for (int i = 0; i < SHA_BLK_WORDS; i++) win[i] <= '0;
      t <= '0;
      blk_ready_o <= 1'b1;
      w_valid_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == ST_IDLE && blk_valid_i) begin
        for (int i = 0; i < SHA_BLK_WORDS; i++) win[i] <= blk_i[BLK_W-1-SHA_WORD_W*i -: SHA_WORD_W];
        t <= '0;
        state <= ST_RUN;
        blk_ready_o <= 1'b0;
        w_valid_o <= 1'b1;
      end else if (state == ST_RUN && round_ready_i) begin
        for (int i = 0; i < SHA_BLK_WORDS - 1; i++) win[i] <= win[i+1];
        win[SHA_BLK_WORDS-1] <= new_w;
        t <= last ? '0 : t + 1'b1;
        if (last) begin
          state <= ST_IDLE;
          blk_ready_o <= 1'b1;
          w_valid_o <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: golden "abc" table, stall/back-to-back/reset sequences and random blocks vs a reference schedule.
module tb_sha256_msg_schedule;
  logic clk = 0, rst = 1, blk_valid = 0, round_ready = 0;
  logic [511:0] blk = '0;
  logic blk_ready, w_valid, last, done;
  logic [31:0] w, k;
  logic [5:0] round;
  int n_pass = 0, n_total = 0;
  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];
  logic [31:0] obs_k [64];
  logic obs_last [64];
  logic [511:0] abc;
  logic [31:0] kt [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  typedef struct {
    int t;
    logic [31:0] w;
    logic [31:0] k;
    logic last;
  } vec_t;
  vec_t vecs [7];
  sha256_msg_schedule dut (
    .clk_i(clk), .rst_i(rst), .blk_valid_i(blk_valid), .blk_ready_o(blk_ready), .blk_i(blk),
    .w_valid_o(w_valid), .round_ready_i(round_ready), .w_o(w), .k_o(k), .round_o(round),
    .last_o(last), .done_o(done)
  );
  always #5 clk = ~clk;
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
  always @(negedge clk) begin
    n_total++;
    if (blk_ready && w_valid) $display("FAIL ready_valid_excl: blk_ready=%b w_valid=%b required not both 1", blk_ready, w_valid);
    else n_pass++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  // Reference: full 64-word schedule computed directly from the block
  function automatic void model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10)) + exp_w[i-7]
               + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3)) + exp_w[i-16];
  endfunction
  task automatic handshake(input logic [511:0] b);
    int n;
    n = 0;
    blk_valid = 1;
    blk = b;
    while (!blk_ready && n < 200) begin
      tick();
      n++;
    end
    check("blk_ready_wait", {31'b0, blk_ready}, 32'd1);
    tick();
    blk_valid = 0;
    blk = {16{$urandom}};
    model(b);
    check("w0_latency_valid", {31'b0, w_valid}, 32'd1);
  endtask
  task automatic rounds(input int stall_t, input int stall_n);
    round_ready = 1;
    for (int t = 0; t < 64; t++) begin
      obs_w[t] = w;
      obs_k[t] = k;
      obs_last[t] = last;
      check($sformatf("round_t%0d", t), {26'b0, round}, t);
      check($sformatf("w_t%0d", t), w, exp_w[t]);
      check($sformatf("k_t%0d", t), k, kt[t]);
      check($sformatf("last_t%0d", t), {31'b0, last}, {31'b0, t == 63});
      check($sformatf("done_low_t%0d", t), {31'b0, done}, 32'd0);
      if (t == stall_t && stall_n > 0) begin
        round_ready = 0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check($sformatf("stall_round_t%0d", t), {26'b0, round}, t);
          check($sformatf("stall_w_t%0d", t), w, exp_w[t]);
          check($sformatf("stall_valid_t%0d", t), {31'b0, w_valid}, 32'd1);
        end
        round_ready = 1;
      end
      tick();
    end
    check("done_pulse", {31'b0, done}, 32'd1);
    check("done_ready", {31'b0, blk_ready}, 32'd1);
    check("done_valid", {31'b0, w_valid}, 32'd0);
  endtask
  task automatic run_block(input logic [511:0] b, input int stall_t, input int stall_n);
    handshake(b);
    rounds(stall_t, stall_n);
    tick();
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask
  task automatic check_abc_table(input string tag);
    foreach (vecs[i]) begin
      check($sformatf("%s_tbl_w_t%0d", tag, vecs[i].t), obs_w[vecs[i].t], vecs[i].w);
      check($sformatf("%s_tbl_k_t%0d", tag, vecs[i].t), obs_k[vecs[i].t], vecs[i].k);
      check($sformatf("%s_tbl_last_t%0d", tag, vecs[i].t), {31'b0, obs_last[vecs[i].t]}, {31'b0, vecs[i].last});
    end
  endtask
  initial begin
    logic [511:0] a, b;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    vecs[0] = '{0, 32'h61626380, 32'h428a2f98, 1'b0};
    vecs[1] = '{1, 32'h00000000, 32'h71374491, 1'b0};
    vecs[2] = '{15, 32'h00000018, 32'hc19bf174, 1'b0};
    vecs[3] = '{16, 32'h61626380, 32'he49b69c1, 1'b0};
    vecs[4] = '{17, 32'h000f0000, 32'hefbe4786, 1'b0};
    vecs[5] = '{62, exp_w[0], 32'hbef9a3f7, 1'b0};
    vecs[6] = '{63, 32'h12b1edeb, 32'hc67178f2, 1'b1};
    model(abc);
    vecs[5].w = exp_w[62];
    tick();
    tick();
    rst = 0;
    check("rst_ready", {31'b0, blk_ready}, 32'd1);
    check("rst_valid", {31'b0, w_valid}, 32'd0);
    check("rst_w", w, 32'd0);
    check("rst_k", k, 32'h428a2f98);
    check("rst_round", {26'b0, round}, 32'd0);
    check("rst_last", {31'b0, last}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    run_block(abc, -1, 0);
    check_abc_table("abc");
    run_block(abc, 10, 5);
    check_abc_table("stall");
    a = {16{$urandom}};
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    handshake(a);
    blk_valid = 1;
    blk = b;
    rounds(-1, 0);
    tick();
    blk_valid = 0;
    model(b);
    check("b2b_valid", {31'b0, w_valid}, 32'd1);
    check("b2b_round", {26'b0, round}, 32'd0);
    check("b2b_w0", w, exp_w[0]);
    check("b2b_done_low", {31'b0, done}, 32'd0);
    rounds(-1, 0);
    tick();
    handshake(abc);
    round_ready = 1;
    for (int i = 0; i < 30; i++) tick();
    check("mid_round", {26'b0, round}, 32'd30);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_valid", {31'b0, w_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, blk_ready}, 32'd1);
    check("mid_rst_round", {26'b0, round}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    tick();
    check("mid_rst_done_after", {31'b0, done}, 32'd0);
    run_block(abc, -1, 0);
    check_abc_table("post_rst");
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 16; i++) a[511 - 32*i -: 32] = $urandom;
      run_block(a, int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
